// File: rtl/sd_data_tx_pkg.sv
// Shared types and constants for the SD 4-bit DAT-line block transmitter.
// Holds the FSM state encoding, the CRC16 generator and the CRC status token codes.
package sd_data_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_START,
    ST_DATA,
    ST_CRC,
    ST_END,
    ST_RELEASE,
    ST_STAT,
    ST_BUSY,
    ST_DONE
  } state_t;

  localparam int          CRC_BITS   = 16;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [2:0]  STAT_OK    = 3'b010;

  // One serial step of CRC16 (x^16+x^12+x^5+1), MSB-first input.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic w_fb;
    w_fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_data_tx_crc16_serial.sv
// Bit-serial CRC16 for one DAT line: accumulates data bits, then shifts the
// remainder out MSB-first on o_msb.
module sd_crc16_serial
  import sd_data_tx_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_shift,
  input  logic i_din,
  output logic o_msb
);

  logic [CRC_BITS-1:0] r_crc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_crc <= '0;
    end else if (i_clr) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= crc16_step(r_crc, i_din);
    end else if (i_shift) begin
      r_crc <= {r_crc[CRC_BITS-2:0], 1'b0};
    end
  end

  assign o_msb = r_crc[CRC_BITS-1];

endmodule

// File: rtl/sd_data_tx.sv
// SD 4-bit DAT write transmitter: start bit, 1024 nibbles, per-line CRC16, end bit,
// then CRC status token and busy. Optional status/busy timeout via SD_TX_TIMEOUT_EN.
module sd_data_tx
  import sd_data_tx_pkg::*;
#(
  parameter int NIBBLES = 1024
`ifdef SD_TX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                       iclk,
  input  logic                       irst_n,
  input  logic                       istart,
  output logic [$clog2(NIBBLES)-1:0] oaddr,
  input  logic [3:0]                 irdata,
  output logic [3:0]                 odata_sd,
  output logic                       odata_sd_en,
  input  logic [3:0]                 idata_sd,
  output logic                       odone,
  output logic                       oerr
);

  localparam int            AW       = $clog2(NIBBLES);
  localparam logic [AW-1:0] LAST_NIB = AW'(NIBBLES - 1);
  localparam logic [AW-1:0] LAST_CRC = AW'(CRC_BITS - 1);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [2:0]    r_stat, w_stat_nxt;
  logic          r_endbit, w_endbit_nxt;
  logic          r_err, w_err_nxt;
  logic          w_crc_clr, w_crc_en, w_crc_shift;
  logic [3:0]    w_crc_bits;
  logic          w_dat0;
  logic          w_unused_dat;

  assign w_dat0       = idata_sd[0];
  assign w_unused_dat = ^idata_sd[3:1];

`ifdef SD_TX_TIMEOUT_EN
  logic [15:0] r_tmo;

  // Counts cycles spent waiting for the card; restarts every time STAT is entered.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_tmo <= '0;
    end else if (r_state == ST_RELEASE) begin
      r_tmo <= '0;
    end else if (r_state == ST_STAT || r_state == ST_BUSY) begin
      r_tmo <= r_tmo + 16'd1;
    end
  end
`endif

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_stat   <= '0;
      r_endbit <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_addr   <= w_addr_nxt;
      r_stat   <= w_stat_nxt;
      r_endbit <= w_endbit_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // r_cnt is the nibble index in DATA, the CRC bit index in CRC and the token bit index in STAT.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_addr_nxt   = r_addr;
    w_stat_nxt   = r_stat;
    w_endbit_nxt = r_endbit;
    w_err_nxt    = r_err;
    w_crc_clr    = 1'b0;
    w_crc_en     = 1'b0;
    w_crc_shift  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_addr_nxt = '0;
        if (istart) begin
          w_state_nxt = ST_PREFETCH;
          w_err_nxt   = 1'b0;
          w_crc_clr   = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      ST_PREFETCH: w_state_nxt = ST_START;
      ST_START: begin
        w_state_nxt = ST_DATA;
        w_cnt_nxt   = '0;
        w_addr_nxt  = AW'(1);
      end
      // Address runs one nibble ahead of the data on the bus because of the RAM read latency.
      ST_DATA: begin
        w_crc_en = 1'b1;
        if (r_cnt == LAST_NIB) begin
          w_state_nxt = ST_CRC;
          w_cnt_nxt   = '0;
          w_addr_nxt  = '0;
        end else begin
          w_cnt_nxt  = r_cnt + AW'(1);
          w_addr_nxt = r_cnt + AW'(2);
        end
      end
      ST_CRC: begin
        w_crc_shift = 1'b1;
        if (r_cnt == LAST_CRC) begin
          w_state_nxt = ST_END;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      ST_END: w_state_nxt = ST_RELEASE;
      ST_RELEASE: begin
        w_state_nxt = ST_STAT;
        w_cnt_nxt   = '0;
      end
      ST_STAT: begin
        if (r_cnt == '0) begin
          if (!w_dat0) w_cnt_nxt = AW'(1);
        end else if (r_cnt <= AW'(3)) begin
          w_stat_nxt = {r_stat[1:0], w_dat0};
          w_cnt_nxt  = r_cnt + AW'(1);
        end else begin
          w_endbit_nxt = w_dat0;
          w_state_nxt  = ST_BUSY;
          w_cnt_nxt    = '0;
        end
      end
      ST_BUSY: begin
        if (w_dat0) begin
          w_state_nxt = ST_DONE;
          w_err_nxt   = !((r_stat == STAT_OK) && r_endbit);
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
`ifdef SD_TX_TIMEOUT_EN
    if ((r_state == ST_STAT || r_state == ST_BUSY) && r_tmo == 16'(TIMEOUT_CYCLES - 1)) begin
      w_state_nxt = ST_DONE;
      w_err_nxt   = 1'b1;
    end
`endif
  end

  for (genvar g = 0; g < 4; g++) begin : g_crc
    sd_crc16_serial u_crc (
      .i_clk   (iclk),
      .i_rst_n (irst_n),
      .i_clr   (w_crc_clr),
      .i_en    (w_crc_en),
      .i_shift (w_crc_shift),
      .i_din   (irdata[g]),
      .o_msb   (w_crc_bits[g])
    );
  end

  // Bus drive decodes straight from the state so an async reset releases DAT at once.
  always_comb begin
    odata_sd    = 4'hF;
    odata_sd_en = 1'b0;
    case (r_state)
      ST_START: begin
        odata_sd    = 4'h0;
        odata_sd_en = 1'b1;
      end
      ST_DATA: begin
        odata_sd    = irdata;
        odata_sd_en = 1'b1;
      end
      ST_CRC: begin
        odata_sd    = w_crc_bits;
        odata_sd_en = 1'b1;
      end
      ST_END:  odata_sd_en = 1'b1;
      default: odata_sd_en = 1'b0;
    endcase
  end

  assign oaddr = r_addr;
  assign odone = (r_state == ST_DONE);
  assign oerr  = r_err;

endmodule

// File: tb/tb_sd_data_tx.sv
// Self-checking bench for sd_data_tx: RAM and card models, polynomial-division CRC
// reference and a per-cycle compare process; honours SD_TX_TIMEOUT_EN.
module tb_sd_data_tx;

  localparam int NIB   = 1024;
  localparam int TMO   = 100;
  localparam int NEVER = 32'h3fffffff;

  logic       iclk = 1'b0;
  logic       irst_n;
  logic       istart;
  logic [9:0] oaddr;
  logic [3:0] irdata;
  logic [3:0] odata_sd;
  logic       odata_sd_en;
  logic [3:0] idata_sd;
  logic       odone;
  logic       oerr;

  always #5 iclk = ~iclk;

`ifdef SD_TX_TIMEOUT_EN
  sd_data_tx #(.NIBBLES(NIB), .TIMEOUT_CYCLES(TMO)) dut (
`else
  sd_data_tx #(.NIBBLES(NIB)) dut (
`endif
    .iclk        (iclk),
    .irst_n      (irst_n),
    .istart      (istart),
    .oaddr       (oaddr),
    .irdata      (irdata),
    .odata_sd    (odata_sd),
    .odata_sd_en (odata_sd_en),
    .idata_sd    (idata_sd),
    .odone       (odone),
    .oerr        (oerr)
  );

  logic [3:0] mem [0:NIB-1];
  always @(posedge iclk) irdata <= mem[oaddr];

  int cycleCnt = 0;
  always @(posedge iclk) cycleCnt <= cycleCnt + 1;

  int          tAcc;
  int          doneK;
  logic        expErr;
  bit          active = 1'b0;
  logic [15:0] lineCrc [4];
  int          testsRun = 0;
  int          failures = 0;

  task automatic checkOutput(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at k=%0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
    end
  endtask

  // Reference CRC: remainder of msg(x)*x^16 divided by the generator, by long division.
  function automatic logic [15:0] crcOfBits(input bit msg[$]);
    bit          work[$];
    logic [16:0] gen;
    logic [15:0] rem;
    gen  = 17'h11021;
    work = msg;
    for (int i = 0; i < 16; i++) work.push_back(1'b0);
    for (int i = 0; i < msg.size(); i++)
      if (work[i])
        for (int j = 0; j <= 16; j++) work[i+j] = work[i+j] ^ gen[16-j];
    for (int j = 0; j < 16; j++) rem[15-j] = work[msg.size()+j];
    return rem;
  endfunction

  task automatic loadBlock(input bit randomData);
    logic [7:0] v;
    for (int b = 0; b < NIB/2; b++) begin
      v = randomData ? 8'($urandom) : 8'h00;
      mem[2*b]   = v[7:4];
      mem[2*b+1] = v[3:0];
    end
    for (int line = 0; line < 4; line++) begin
      bit q[$];
      for (int n = 0; n < NIB; n++) q.push_back(mem[n][line]);
      lineCrc[line] = crcOfBits(q);
    end
  endtask

  function automatic logic [3:0] expData(input int k);
    int b;
    if (k == 1) return 4'h0;
    if (k >= 2 && k <= NIB + 1) return mem[k-2];
    if (k >= NIB + 2 && k <= NIB + 17) begin
      b = 15 - (k - (NIB + 2));
      return {lineCrc[3][b], lineCrc[2][b], lineCrc[1][b], lineCrc[0][b]};
    end
    return 4'hF;
  endfunction

  // Every cycle of an active transfer is checked against the frame layout relative to acceptance.
  always @(negedge iclk) begin
    int k;
    if (active) begin
      k = cycleCnt - tAcc;
      checkOutput("en", k, 32'(odata_sd_en), 32'(k >= 1 && k <= NIB + 18));
      if (k >= 1 && k <= NIB + 18) checkOutput("data", k, 32'(odata_sd), 32'(expData(k)));
      if (k <= NIB + 2) checkOutput("addr", k, 32'(oaddr), (k >= 1 && k <= NIB) ? 32'(k - 1) : 32'd0);
      checkOutput("done", k, 32'(odone), 32'(k == doneK));
      checkOutput("err", k, 32'(oerr), (k >= doneK) ? 32'(expErr) : 32'd0);
    end
  end

  task automatic waitUntil(input int k);
    while (cycleCnt - tAcc < k) begin
      @(posedge iclk);
      #2;
    end
  endtask

  task automatic startXfer();
    @(posedge iclk);
    #2 istart = 1'b1;
    @(posedge iclk);
    #2 istart = 1'b0;
    tAcc   = cycleCnt;
    active = 1'b1;
  endtask

  task automatic applyStimulus(input int delay, input logic [2:0] st, input logic eb, input int busy,
                               input bit noToken, input int glitchK, input bit startAtDone);
    logic q[$];
    if (noToken) begin
`ifdef SD_TX_TIMEOUT_EN
      doneK = NIB + 20 + TMO;
`else
      doneK = NEVER;
`endif
      expErr = 1'b1;
      q.push_back(1'b1);
    end else begin
      for (int i = 0; i < delay; i++) q.push_back(1'b1);
      q.push_back(1'b0);
      q.push_back(st[2]);
      q.push_back(st[1]);
      q.push_back(st[0]);
      q.push_back(eb);
      for (int i = 0; i < busy; i++) q.push_back(1'b0);
      q.push_back(1'b1);
      doneK  = NIB + 20 + delay + 6 + busy;
      expErr = !(st == 3'b010 && eb);
    end
    startXfer();
    if (glitchK > 0) begin
      waitUntil(glitchK);
      istart = 1'b1;
      waitUntil(glitchK + 1);
      istart = 1'b0;
    end
    for (int i = 0; i < q.size(); i++) begin
      waitUntil(NIB + 20 + i);
      idata_sd = {3'($urandom), q[i]};
    end
    if (doneK == NEVER) begin
      waitUntil(10000);
      active = 1'b0;
      return;
    end
    if (startAtDone) istart = 1'b1;
    waitUntil(doneK + 1);
    istart = 1'b0;
    active = 1'b0;
    if (startAtDone) begin
      repeat (3) begin
        @(negedge iclk);
        checkOutput("idleEn", cycleCnt - tAcc, 32'(odata_sd_en), 32'd0);
        checkOutput("idleDone", cycleCnt - tAcc, 32'(odone), 32'd0);
      end
    end
  endtask

  task automatic resetDut();
    irst_n = 1'b0;
    #1;
    checkOutput("rstEn", 0, 32'(odata_sd_en), 32'd0);
    checkOutput("rstData", 0, 32'(odata_sd), 32'hF);
    checkOutput("rstAddr", 0, 32'(oaddr), 32'd0);
    checkOutput("rstDone", 0, 32'(odone), 32'd0);
    checkOutput("rstErr", 0, 32'(oerr), 32'd0);
    repeat (2) @(posedge iclk);
    #2 irst_n = 1'b1;
  endtask

  task automatic resetMid();
    bit sawDone;
    loadBlock(1'b1);
    doneK  = NEVER;
    expErr = 1'b0;
    startXfer();
    waitUntil(500);
    active = 1'b0;
    irst_n = 1'b0;
    #1;
    checkOutput("midRstEn", 500, 32'(odata_sd_en), 32'd0);
    checkOutput("midRstAddr", 500, 32'(oaddr), 32'd0);
    sawDone = 1'b0;
    repeat (20) begin
      @(negedge iclk);
      if (odone) sawDone = 1'b1;
    end
    checkOutput("midRstNoDone", 520, 32'(sawDone), 32'd0);
    @(posedge iclk);
    #2 irst_n = 1'b1;
    applyStimulus(0, 3'b010, 1'b1, 3, 1'b0, 0, 1'b0);
  endtask

  initial begin
    bit       pq[$];
    string    s;
    byte      c;
    irst_n   = 1'b0;
    istart   = 1'b0;
    idata_sd = 4'hF;
    tAcc     = 0;
    doneK    = NEVER;
    expErr   = 1'b0;

    s = "123456789";
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      for (int b = 7; b >= 0; b--) pq.push_back(c[b]);
    end
    checkOutput("modelCrcAscii", 0, 32'(crcOfBits(pq)), 32'h31C3);
    pq.delete();
    for (int i = 0; i < NIB - 1; i++) pq.push_back(1'b0);
    pq.push_back(1'b1);
    checkOutput("modelCrcX16", 0, 32'(crcOfBits(pq)), 32'h1021);
    pq.delete();
    for (int i = 0; i < NIB - 2; i++) pq.push_back(1'b0);
    pq.push_back(1'b1);
    pq.push_back(1'b0);
    checkOutput("modelCrcX17", 0, 32'(crcOfBits(pq)), 32'h2042);

    loadBlock(1'b0);
    checkOutput("modelCrcZero", 0, 32'(lineCrc[0] | lineCrc[1] | lineCrc[2] | lineCrc[3]), 32'h0);
    repeat (2) @(posedge iclk);
    resetDut();

    applyStimulus(0, 3'b010, 1'b1, 5, 1'b0, 0, 1'b0);
    loadBlock(1'b1);
    applyStimulus($urandom_range(0, 3), 3'b010, 1'b1, $urandom_range(0, 8), 1'b0, 600, 1'b0);
    loadBlock(1'b1);
    applyStimulus($urandom_range(0, 3), 3'b010, 1'b1, $urandom_range(0, 8), 1'b0, 0, 1'b1);
    loadBlock(1'b1);
    applyStimulus(1, 3'b101, 1'b1, 3, 1'b0, 0, 1'b0);
    applyStimulus(0, 3'b010, 1'b1, 2, 1'b0, 0, 1'b0);
    applyStimulus(0, 3'b010, 1'b0, 4, 1'b0, 0, 1'b0);
    applyStimulus(2, 3'b110, 1'b1, 0, 1'b0, 0, 1'b0);
    applyStimulus(0, 3'b000, 1'b1, 0, 1'b1, 0, 1'b0);
`ifndef SD_TX_TIMEOUT_EN
    resetDut();
`endif
    resetMid();

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
